line_scan_sequencer: RTL and testbench

- Round-robin line-select sequencer that sits directly upstream of the 6:64 one-hot decoder.
- Takes a 64-bit request bitmap and picks the next requesting line in circular order starting from a rotating pointer.
- Presents the 6-bit line index to the decoder with a valid/ready handshake.
- Holds each accepted selection for a programmable dwell time before choosing the next line.

---
 rtl/line_scan_sequencer_pkg.sv | 15 +
 rtl/line_scan_sequencer_rr_find_next.sv | 36 +++
 rtl/line_scan_sequencer.sv | 118 +++++++++++
 tb/tb_line_scan_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_scan_sequencer_pkg.sv
// Shared constants and FSM state encoding for the line-scan sequencer
// that feeds the 6:64 one-hot line decoder.
package line_scan_pkg;

   localparam int N_LINES = 64;
   localparam int IDX_W   = $clog2(N_LINES);
   localparam int DWELL_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      DWELL = 2'd2
   } state_t;

endpackage

// File: rtl/line_scan_sequencer_rr_find_next.sv
// Circular first-set-bit search: the lowest requesting line at or after ptr,
// wrapping past the top line back to line 0.
module rr_find_next #(
   parameter int N_LINES = 64,
   parameter int IDX_W   = 6
) (
   input  logic [N_LINES-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [IDX_W:0]       w_lshift;
   logic [N_LINES-1:0]   w_rot;
   logic [IDX_W-1:0]     w_off;

   // Rotate right by ptr so the search always starts at bit 0; a left shift
   // by N_LINES (ptr=0) yields zero, leaving the plain right shift.
   assign w_lshift = (IDX_W+1)'(N_LINES) - {1'b0, ptr_i};
   assign w_rot    = (req_i >> ptr_i) | (req_i << w_lshift);

   always_comb begin
      // NOTE: w_off gets a default before the loop so every path assigns it;
      // a combinational block with an unassigned path would infer a latch.
      w_off = '0;
      for (int i = N_LINES - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = IDX_W'(i);
         end
      end
   end

   assign found_o = |req_i;
   assign idx_o   = w_off + ptr_i;

endmodule

// File: rtl/line_scan_sequencer.sv
// Round-robin line-select sequencer: offers the next requesting line index
// over valid/ready, then holds it for a programmable dwell time.
module line_scan_sequencer #(
   parameter int N_LINES = line_scan_pkg::N_LINES,
   parameter int IDX_W   = $clog2(N_LINES),
   parameter int DWELL_W = line_scan_pkg::DWELL_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [N_LINES-1:0] req_i,
   input  logic [DWELL_W-1:0] dwell_i,
   output logic [IDX_W-1:0]   idx_o,
   output logic               idx_valid_o,
   input  logic               idx_ready_i,
   output logic               busy_o,
   output logic               wrap_o
);

   import line_scan_pkg::*;

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
   logic [IDX_W-1:0]   r_last_idx, w_last_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
   logic               r_have_last, w_have_last_nxt;
   logic               r_valid, r_busy;
   logic               r_wrap, w_wrap_nxt;
   logic               w_found, w_handshake;
   logic [IDX_W-1:0]   w_sel;

   rr_find_next #(
      .N_LINES (N_LINES),
      .IDX_W   (IDX_W)
   ) u_find (
      .req_i   (req_i),
      .ptr_i   (r_ptr),
      .found_o (w_found),
      .idx_o   (w_sel)
   );

   assign w_handshake = r_valid & idx_ready_i;

   always_comb begin
      w_state_nxt     = r_state;
      w_ptr_nxt       = r_ptr;
      w_last_nxt      = r_last_idx;
      w_have_last_nxt = r_have_last;
      w_idx_nxt       = r_idx;
      w_cnt_nxt       = r_cnt;
      w_wrap_nxt      = 1'b0;

      case (r_state)
         IDLE: begin
            if (en && w_found) begin
               w_state_nxt = OFFER;
               w_idx_nxt   = w_sel;
            end
         end
         OFFER: begin
            // req_i and en are ignored here: an offer is never retracted.
            if (w_handshake) begin
               w_ptr_nxt       = r_idx + IDX_W'(1);
               w_last_nxt      = r_idx;
               w_have_last_nxt = 1'b1;
               w_wrap_nxt      = r_have_last && (r_idx <= r_last_idx);
               if (dwell_i == '0) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt   = dwell_i;
                  w_state_nxt = DWELL;
               end
            end
         end
         DWELL: begin
            if (r_cnt <= DWELL_W'(1)) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - DWELL_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_last_idx  <= '0;
         r_have_last <= 1'b0;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_last_idx  <= w_last_nxt;
         r_have_last <= w_have_last_nxt;
         r_idx       <= w_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_valid     <= (w_state_nxt == OFFER);
         r_busy      <= (w_state_nxt != IDLE);
         r_wrap      <= w_wrap_nxt;
      end
   end

   assign idx_o       = r_idx;
   assign idx_valid_o = r_valid;
   assign busy_o      = r_busy;
   assign wrap_o      = r_wrap;

endmodule

// File: tb/tb_line_scan_sequencer.sv
// Self-checking bench for line_scan_sequencer against a transaction-level
// round-robin model (pointer, last accepted index, wrap rule).
module tb_line_scan_sequencer;

   localparam int N  = 64;
   localparam int IW = 6;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [N-1:0]  req;
   logic [DW-1:0] dwell;
   logic [IW-1:0] idx;
   logic          valid;
   logic          ready;
   logic          busy;
   logic          wrap;

   int errors = 0;
   int checks = 0;

   int m_ptr  = 0;
   int m_last = 0;
   bit m_have = 1'b0;

   line_scan_sequencer #(
      .N_LINES (N),
      .IDX_W   (IW),
      .DWELL_W (DW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .req_i       (req),
      .dwell_i     (dwell),
      .idx_o       (idx),
      .idx_valid_o (valid),
      .idx_ready_i (ready),
      .busy_o      (busy),
      .wrap_o      (wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic int model_sel(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic model_wrap(input int sel);
      return m_have && (sel <= m_last);
   endfunction

   task automatic model_accept(input int sel);
      m_ptr  = (sel + 1) % N;
      m_last = sel;
      m_have = 1'b1;
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_last = 0;
      m_have = 1'b0;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic reset_dut();
      en    = 1'b0;
      req   = '0;
      dwell = '0;
      ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (valid !== 1'b1 && n < budget);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      req   = '1;
      ready = 1'b1;
      dwell = 8'd7;
      repeat (2) @(negedge clk);
      checks++; if (idx !== '0)    begin errors++; $display("FAIL reset_idx: got %0d expected 0", idx); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (wrap !== 1'b0)  begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
      en = 1'b0; req = '0; ready = 1'b0; dwell = '0;
      rst_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      checks++; if (valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL idle_en0: valid=%b busy=%b expected 0 0", valid, busy);
      end
   endtask

   task automatic test_round_robin();
      int   exp_idx;
      logic exp_wrap;
      reset_dut();
      en = 1'b1; req = 64'h0000_0000_0001_0010; ready = 1'b1; dwell = '0;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         exp_idx = model_sel(req, m_ptr);
         checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", t, valid); end
         checks++; if (idx !== 6'(exp_idx)) begin errors++; $display("FAIL rr_idx[%0d]: got %0d expected %0d", t, idx, exp_idx); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy[%0d]: got %b expected 1", t, busy); end
         exp_wrap = model_wrap(exp_idx);
         model_accept(exp_idx);
         @(negedge clk);
         checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL rr_wrap[%0d]: got %b expected %b", t, wrap, exp_wrap); end
         checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d]: valid=%b expected 0", t, valid); end
      end
      en = 1'b0;
   endtask

   task automatic test_hold();
      int   exp_idx;
      logic exp_wrap;
      reset_dut();
      en = 1'b1; ready = 1'b0; dwell = '0;
      req = (64'd1 << 9) | (64'd1 << 12);
      @(negedge clk);
      exp_idx = model_sel(req, m_ptr);
      checks++; if (valid !== 1'b1 || idx !== 6'(exp_idx)) begin
         errors++; $display("FAIL hold_offer: valid=%b idx=%0d expected 1 %0d", valid, idx, exp_idx);
      end
      req = (64'd1 << 12) | (64'd1 << 2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (valid !== 1'b1 || idx !== 6'(exp_idx)) begin
            errors++; $display("FAIL hold_stable[%0d]: valid=%b idx=%0d expected 1 %0d", c, valid, idx, exp_idx);
         end
      end
      ready = 1'b1;
      exp_wrap = model_wrap(exp_idx);
      model_accept(exp_idx);
      @(negedge clk);
      checks++; if (valid !== 1'b0 || wrap !== exp_wrap) begin
         errors++; $display("FAIL hold_accept: valid=%b wrap=%b expected 0 %b", valid, wrap, exp_wrap);
      end
      req = (64'd1 << 2) | (64'd1 << 9) | (64'd1 << 12);
      @(negedge clk);
      exp_idx = model_sel(req, m_ptr);
      checks++; if (valid !== 1'b1 || idx !== 6'(exp_idx)) begin
         errors++; $display("FAIL hold_ptr: valid=%b idx=%0d expected 1 %0d", valid, idx, exp_idx);
      end
      exp_wrap = model_wrap(exp_idx);
      model_accept(exp_idx);
      @(negedge clk);
      checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL hold_wrap: got %b expected %b", wrap, exp_wrap); end
      en = 1'b0; ready = 1'b0;
   endtask

   task automatic test_dwell();
      int   exp_idx;
      logic exp_wrap;
      int   n;
      reset_dut();
      dwell = 8'd3; req = 64'd1 << 63; en = 1'b1; ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         wait_valid(8, n);
         checks++; if (valid !== 1'b1 || n != 1) begin
            errors++; $display("FAIL dwell_latency[%0d]: valid=%b cycles=%0d expected 1 1", t, valid, n);
         end
         exp_idx = model_sel(req, m_ptr);
         checks++; if (idx !== 6'(exp_idx)) begin errors++; $display("FAIL dwell_idx[%0d]: got %0d expected %0d", t, idx, exp_idx); end
         exp_wrap = model_wrap(exp_idx);
         model_accept(exp_idx);
         @(negedge clk);
         checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL dwell_wrap[%0d]: got %b expected %b", t, wrap, exp_wrap); end
         n = 0;
         while (busy === 1'b1 && valid === 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
         end
         checks++; if (n != 3) begin errors++; $display("FAIL dwell_len[%0d]: got %0d expected 3", t, n); end
         checks++; if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++; $display("FAIL dwell_idle[%0d]: busy=%b valid=%b expected 0 0", t, busy, valid);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_wrap_boundary();
      logic [N-1:0]  tbl_req  [4];
      logic [DW-1:0] tbl_dw   [4];
      int            tbl_idx  [4];
      logic          tbl_wrap [4];
      int            n;
      tbl_req[0] = 64'd1 << 63;                  tbl_dw[0] = 8'd0;   tbl_idx[0] = 63; tbl_wrap[0] = 1'b0;
      tbl_req[1] = (64'd1 << 63) | 64'd1;        tbl_dw[1] = 8'd0;   tbl_idx[1] = 0;  tbl_wrap[1] = 1'b1;
      tbl_req[2] = 64'd1 << 62;                  tbl_dw[2] = 8'd0;   tbl_idx[2] = 62; tbl_wrap[2] = 1'b0;
      tbl_req[3] = 64'd1;                        tbl_dw[3] = 8'd255; tbl_idx[3] = 0;  tbl_wrap[3] = 1'b1;
      reset_dut();
      en = 1'b1; ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         req = tbl_req[t]; dwell = tbl_dw[t];
         @(negedge clk);
         checks++; if (valid !== 1'b1 || idx !== 6'(tbl_idx[t])) begin
            errors++; $display("FAIL bound_idx[%0d]: valid=%b idx=%0d expected 1 %0d", t, valid, idx, tbl_idx[t]);
         end
         model_accept(tbl_idx[t]);
         @(negedge clk);
         checks++; if (wrap !== tbl_wrap[t]) begin errors++; $display("FAIL bound_wrap[%0d]: got %b expected %b", t, wrap, tbl_wrap[t]); end
         n = 0;
         while (busy === 1'b1 && valid === 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
         end
         checks++; if (n != int'(tbl_dw[t])) begin errors++; $display("FAIL bound_dwell[%0d]: got %0d expected %0d", t, n, tbl_dw[t]); end
      end
      en = 1'b0; dwell = '0;
   endtask

   task automatic test_async_reset();
      reset_dut();
      en = 1'b1; ready = 1'b0; dwell = '0; req = 64'd1 << 20;
      @(negedge clk);
      checks++; if (valid !== 1'b1 || idx !== 6'd20) begin
         errors++; $display("FAIL arst_offer: valid=%b idx=%0d expected 1 20", valid, idx);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", valid); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
      checks++; if (idx !== '0)     begin errors++; $display("FAIL arst_idx: got %0d expected 0", idx); end
      @(negedge clk);
      req = 64'd1 << 5; ready = 1'b1;
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      checks++; if (valid !== 1'b1 || idx !== 6'd5) begin
         errors++; $display("FAIL arst_first: valid=%b idx=%0d expected 1 5", valid, idx);
      end
      model_accept(5);
      @(negedge clk);
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL arst_wrap: got %b expected 0", wrap); end
      en = 1'b0; ready = 1'b0;
   endtask

   task automatic test_en_dwell();
      int   exp_idx;
      logic exp_wrap;
      int   n;
      reset_dut();
      en = 1'b1; ready = 1'b0; dwell = 8'd4; req = 64'd1 << 7;
      @(negedge clk);
      checks++; if (valid !== 1'b1 || idx !== 6'd7) begin
         errors++; $display("FAIL en_offer: valid=%b idx=%0d expected 1 7", valid, idx);
      end
      en = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checks++; if (valid !== 1'b1 || idx !== 6'd7) begin
            errors++; $display("FAIL en_keep: valid=%b idx=%0d expected 1 7", valid, idx);
         end
      end
      ready = 1'b1;
      model_accept(7);
      @(negedge clk);
      checks++; if (valid !== 1'b0 || busy !== 1'b1 || wrap !== 1'b0) begin
         errors++; $display("FAIL en_accept: valid=%b busy=%b wrap=%b expected 0 1 0", valid, busy, wrap);
      end
      n = 0;
      while (busy === 1'b1 && valid === 1'b0 && n < 400) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n != 4) begin errors++; $display("FAIL en_dwell_len: got %0d expected 4", n); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++; if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL en_idle[%0d]: valid=%b busy=%b expected 0 0", c, valid, busy);
         end
      end
      en = 1'b1;
      @(negedge clk);
      exp_idx = model_sel(req, m_ptr);
      checks++; if (valid !== 1'b1 || idx !== 6'(exp_idx)) begin
         errors++; $display("FAIL en_resume: valid=%b idx=%0d expected 1 %0d", valid, idx, exp_idx);
      end
      exp_wrap = model_wrap(exp_idx);
      model_accept(exp_idx);
      @(negedge clk);
      checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL en_wrap: got %b expected %b", wrap, exp_wrap); end
      en = 1'b0; ready = 1'b0; dwell = '0;
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      int           exp_idx;
      logic         exp_wrap;
      int           d;
      int           hold;
      int           n;
      reset_dut();
      en = 1'b1; ready = 1'b0;
      for (int it = 0; it < 40; it++) begin
         r = {$urandom(), $urandom()};
         case ($urandom_range(0, 2))
            0:       r = 64'd1 << $urandom_range(0, 63);
            1:       r = r & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            default: ;
         endcase
         if (r == '0) r[0] = 1'b1;
         req = r;
         d = $urandom_range(0, 5);
         dwell = DW'(d);
         wait_valid(4, n);
         checks++; if (valid !== 1'b1 || n != 1) begin
            errors++; $display("FAIL rnd_latency[%0d]: valid=%b cycles=%0d expected 1 1", it, valid, n);
         end
         exp_idx = model_sel(r, m_ptr);
         checks++; if (idx !== 6'(exp_idx)) begin errors++; $display("FAIL rnd_idx[%0d]: got %0d expected %0d", it, idx, exp_idx); end
         hold = $urandom_range(0, 3);
         for (int h = 0; h < hold; h++) begin
            req = {$urandom(), $urandom()};
            @(negedge clk);
            checks++; if (valid !== 1'b1 || idx !== 6'(exp_idx)) begin
               errors++; $display("FAIL rnd_hold[%0d]: valid=%b idx=%0d expected 1 %0d", it, valid, idx, exp_idx);
            end
         end
         ready = 1'b1;
         exp_wrap = model_wrap(exp_idx);
         model_accept(exp_idx);
         @(negedge clk);
         ready = 1'b0;
         checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL rnd_wrap[%0d]: got %b expected %b", it, wrap, exp_wrap); end
         n = 0;
         while (busy === 1'b1 && valid === 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
         end
         checks++; if (n != d || busy !== 1'b0 || valid !== 1'b0) begin
            errors++; $display("FAIL rnd_dwell[%0d]: cycles=%0d busy=%b valid=%b expected %0d 0 0", it, n, busy, valid, d);
         end
      end
      en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = '0;
      dwell = '0;
      ready = 1'b0;
      test_reset();
      test_round_robin();
      test_hold();
      test_dwell();
      test_wrap_boundary();
      test_async_reset();
      test_en_dwell();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
